// File: rtl/soc_system_mem_rdy_pkg.sv
// Shared definitions for the mem_rdy controller: FSM state encoding,
// Avalon register addresses and register bit positions.
package soc_system_mem_rdy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_CTRL    = 2'd1;
  localparam logic [1:0] ADDR_ACK     = 2'd2;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

  localparam int CTRL_START        = 0;
  localparam int CTRL_AUTO_RESTART = 1;
  localparam int CTRL_CLR_TIMEOUT  = 2;
  localparam int CTRL_IRQ_EN       = 3;

  localparam int STATUS_MEM_RDY = 0;
  localparam int STATUS_BUSY    = 1;
  localparam int STATUS_TIMEOUT = 2;
  localparam int STATUS_CNT_LSB = 8;

endpackage

// File: rtl/soc_system_mem_rdy_timer.sv
// READY-state timeout counter. Loaded with the reload value when a fill
// completes, counts down while enabled and flags expiry when the count
// reaches 1. A zero reload leaves the timer disarmed so it never expires.
module soc_system_mem_rdy_timer #(
  parameter int TIMEOUT_W = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] reload,
  output logic                 expire
);

  logic [TIMEOUT_W-1:0] count;
  logic                 armed;

  // Load on fill completion, otherwise count down while enabled, holding at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      armed <= 1'b0;
    end else if (load) begin
      count <= reload;
      armed <= |reload;
    end else if (enable && (count != '0)) begin
      count <= count - TIMEOUT_W'(1);
    end
  end

  assign expire = enable && armed && (count == TIMEOUT_W'(1));

endmodule

// File: rtl/soc_system_mem_rdy_ctrl.sv
// Sequences the fabric memory fill and the HPS handshake behind mem_rdy.
// The HPS starts a fill over a small Avalon-MM slave, the block pulses
// fill_start, waits for fill_done, then holds mem_rdy until the HPS
// acknowledges or the READY timeout expires.
// Optional interrupt output: define SOC_SYSTEM_MEM_RDY_IRQ_EN.
module soc_system_mem_rdy_ctrl
  import soc_system_mem_rdy_pkg::*;
#(
  parameter int TIMEOUT_W = 24,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        fill_start,
  input  logic        fill_done,
  output logic        mem_rdy
`ifdef SOC_SYSTEM_MEM_RDY_IRQ_EN
  ,
  output logic        irq
`endif
);

  state_t               state;
  logic                 auto_restart;
  logic [TIMEOUT_W-1:0] timeout_reload;
  logic                 timeout_flag;
  logic [CNT_W-1:0]     fill_count;
`ifdef SOC_SYSTEM_MEM_RDY_IRQ_EN
  logic                 irq_en;
`endif

  logic        wr_ctrl;
  logic        wr_timeout;
  logic        start_req;
  logic        clr_req;
  logic        ack_req;
  logic        timer_load;
  logic        timer_en;
  logic        timer_expire;
  logic [31:0] rd_next;
  logic        unused_wdata;

  assign wr_ctrl      = write && (address == ADDR_CTRL);
  assign wr_timeout   = write && (address == ADDR_TIMEOUT);
  assign start_req    = wr_ctrl && writedata[CTRL_START];
  assign clr_req      = wr_ctrl && writedata[CTRL_CLR_TIMEOUT];
  assign ack_req      = write && (address == ADDR_ACK) && writedata[0];
  assign timer_load   = (state == FILL) && fill_done;
  assign timer_en     = (state == READY);
  assign unused_wdata = ^writedata;

  soc_system_mem_rdy_timer #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (timer_load),
    .enable (timer_en),
    .reload (timeout_reload),
    .expire (timer_expire)
  );

  // Software-writable configuration: CTRL persistent bits and TIMEOUT reload
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_restart   <= 1'b0;
      timeout_reload <= '0;
`ifdef SOC_SYSTEM_MEM_RDY_IRQ_EN
      irq_en         <= 1'b0;
`endif
    end else begin
      if (wr_ctrl) begin
        auto_restart <= writedata[CTRL_AUTO_RESTART];
`ifdef SOC_SYSTEM_MEM_RDY_IRQ_EN
        irq_en       <= writedata[CTRL_IRQ_EN];
`endif
      end
      if (wr_timeout) begin
        timeout_reload <= writedata[TIMEOUT_W-1:0];
      end
    end
  end

  // Fill/handshake FSM with registered fill_start, mem_rdy, timeout flag and fill count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      fill_start   <= 1'b0;
      mem_rdy      <= 1'b0;
      timeout_flag <= 1'b0;
      fill_count   <= '0;
    end else begin
      fill_start <= 1'b0;
      if (clr_req) begin
        timeout_flag <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start_req) begin
            state      <= FILL;
            fill_start <= 1'b1;
          end
        end
        FILL: begin
          if (fill_done) begin
            state      <= READY;
            mem_rdy    <= 1'b1;
            fill_count <= fill_count + CNT_W'(1);
          end
        end
        READY: begin
          if (ack_req) begin
            mem_rdy <= 1'b0;
            if (auto_restart) begin
              state      <= FILL;
              fill_start <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (timer_expire) begin
            timeout_flag <= 1'b1;
            mem_rdy      <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          mem_rdy <= 1'b0;
        end
      endcase
    end
  end

  // Register read mux; ACK and pulse bits read back as zero
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_STATUS: begin
        rd_next[STATUS_MEM_RDY]               = mem_rdy;
        rd_next[STATUS_BUSY]                  = (state == FILL);
        rd_next[STATUS_TIMEOUT]               = timeout_flag;
        rd_next[STATUS_CNT_LSB +: CNT_W]      = fill_count;
      end
      ADDR_CTRL: begin
        rd_next[CTRL_AUTO_RESTART] = auto_restart;
`ifdef SOC_SYSTEM_MEM_RDY_IRQ_EN
        rd_next[CTRL_IRQ_EN]       = irq_en;
`else
        rd_next[CTRL_IRQ_EN]       = 1'b0;
`endif
      end
      ADDR_TIMEOUT: begin
        rd_next[TIMEOUT_W-1:0] = timeout_reload;
      end
      default: begin
        rd_next = '0;
      end
    endcase
  end

  // Registered read data, updated every cycle from the current address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

`ifdef SOC_SYSTEM_MEM_RDY_IRQ_EN
  // Interrupt follows the enabled sources, registered one cycle behind them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en & (mem_rdy | timeout_flag);
    end
  end
`endif

endmodule

// File: doc/soc_system_mem_rdy_ctrl.md
Name: soc_system_mem_rdy_ctrl

Overview:
- Sequences the FPGA-side memory fill and the HPS handshake behind the mem_rdy flag.
- The HPS starts a fill over an Avalon-MM slave. The block pulses fill_start and waits for fill_done from fabric logic.
- It then raises mem_rdy, which drives the existing PIO in_port, until the HPS acknowledges or a timeout expires.
- Sits between the HPS lightweight bridge and the fabric fill engine.

Parameters:
- TIMEOUT_W, 24, width of the READY-state timeout counter and its reload register.
- CNT_W, 8, width of the completed-fill counter reported in STATUS.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  Avalon-MM word address.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, registered.
- fill_start  out  1  one-cycle pulse requesting a fill.
- fill_done  in  1  fill complete; sampled only in FILL.
- mem_rdy  out  1  buffer ready for HPS; connects to the PIO in_port.
- irq  out  1  present only with the optional feature.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on reset_n. Every flop clears on reset_n=0 regardless of clk.
- Reset values:
  - state=IDLE.
  - readdata=0, fill_start=0, mem_rdy=0, irq=0.
  - CTRL=0, TIMEOUT reload=0 (timeout disabled), timeout flag=0, fill count=0.
- Register map:
  - addr0 STATUS (RO): bit0 mem_rdy, bit1 busy (state==FILL), bit2 timeout (sticky), bits[8+CNT_W-1:8] fill count.
  - addr1 CTRL (RW): bit0 start (write-1 pulse, reads 0), bit1 auto_restart, bit2 clr_timeout (write-1 pulse, reads 0), bit3 irq_en (reads 0 without the feature).
  - addr2 ACK (WO, reads 0): a write with writedata[0]=1 acknowledges.
  - addr3 TIMEOUT (RW): reload value, TIMEOUT_W bits zero-extended.
- Reads: readdata updates every clk with a mux of address, so the value appears on the cycle after address is presented. The read slave is always enabled; there is no read strobe. A write and a read of the same register in the same cycle return the pre-write value.
- FSM, states IDLE, FILL, READY:
  - IDLE: on a CTRL write with start=1, go to FILL and assert fill_start for exactly one cycle, on the transition edge.
  - FILL: on fill_done=1, go to READY. In the same edge, set mem_rdy=1, increment fill count (wraps from all-ones to 0), and load the timer with TIMEOUT.
  - READY, ACK seen: clear mem_rdy. If auto_restart=1, go to FILL and pulse fill_start. Otherwise go to IDLE.
  - READY, timer reaches 1 with TIMEOUT!=0: set the timeout flag, clear mem_rdy, go to IDLE. auto_restart is ignored on this path.
- Timer: decrements once per cycle in READY. TIMEOUT=0 means it never expires. A TIMEOUT write during READY takes effect at the next load only.
- Simultaneous events:
  - ACK and expiry in the same cycle: ACK wins, no timeout flag.
  - clr_timeout and a new timeout in the same cycle: set wins.
- Ignored inputs:
  - start in FILL or READY.
  - ACK outside READY.
  - fill_done outside FILL.
- mem_rdy is a registered state decode and glitch-free.
- Reset mid-operation: everything returns immediately to reset values, and fill_start never stretches across reset.

Optional Feature:
- Macro: SOC_SYSTEM_MEM_RDY_IRQ_EN.
- Defined: irq port exists and is registered; irq = mem_rdy & CTRL.irq_en, or timeout flag & CTRL.irq_en. irq de-asserts the cycle after ACK or clr_timeout clears the source.
- Undefined: no irq port, no irq flop, CTRL bit3 is not stored and reads 0.

Decomposition:
- Package soc_system_mem_rdy_pkg holds:
  - state encoding IDLE=2'd0, FILL=2'd1, READY=2'd2;
  - register address constants ADDR_STATUS/CTRL/ACK/TIMEOUT;
  - CTRL and STATUS bit-index constants.
- Sub-module soc_system_mem_rdy_timer: loadable TIMEOUT_W down-counter with load, enable and expire (count==1, reload!=0).

Test Plan:
- Reset release, read addr0 → readdata=0. Write CTRL=1 → fill_start high exactly 1 cycle, STATUS.busy=1.
- fill_done pulse in FILL → mem_rdy=1 next cycle, STATUS=0x101. Write ACK=1 → mem_rdy=0, state IDLE.
- TIMEOUT=5, full fill, no ACK → mem_rdy drops after 5 READY cycles, STATUS bit2=1. CTRL=4 → bit2=0.
- auto_restart=1, ACK in READY → fill_start pulses the cycle after ACK, no IDLE cycle. Run 256 fills → count wraps to 0.
- ACK written on the exact expiry cycle (TIMEOUT=3) → timeout flag stays 0. start while READY → no fill_start.
- With SOC_SYSTEM_MEM_RDY_IRQ_EN and CTRL=8, complete a fill → irq=1. ACK → irq=0 next cycle. Assert reset_n=0 mid-FILL → all outputs 0 asynchronously.
